// File: rtl/sad_abs_diff_accumulator.sv
// ============================================================================
// Module   : sad_abs_diff_accumulator
// Purpose  : Streaming sum-of-absolute-differences engine over WINDOW byte
//            pairs, with valid/ready handshakes on input and output.
// Options  : SAD_SPIKE_EN adds the thresh input and the spike output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sad_abs_diff_accumulator #(
    parameter int WIDTH  = 8,
    parameter int WINDOW = 16,
    parameter int ACC_W  = 12,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] sad,
    output logic             busy
`ifdef SAD_SPIKE_EN
    ,
    input  logic [ACC_W-1:0] thresh,
    output logic             spike
`endif
);

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_window = CNT_W'(WINDOW);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [ACC_W-1:0]   r_acc;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_mag;
    logic [WIDTH-1:0]   r_d;
    logic [WIDTH-1:0]   r_mag;
    logic               r_borrow;
    logic               r_v1;
    logic               r_v2;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_sad;
    logic               w_accept;
    logic               w_load;
    logic               w_release;

    assign in_ready  = (r_state == ST_ACCUM) && (r_count < c_window);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign sad       = r_sad;
    assign busy      = !((r_state == ST_ACCUM) && (r_count == '0));

    // a - b as a + ~b + 1; a clear carry-out means the result went negative
    assign w_diff = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    assign w_mag  = r_borrow ? (~r_d + WIDTH'(1)) : r_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACCUM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            ST_ACCUM: begin
                if (w_accept && (r_count == c_window - CNT_W'(1))) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_v1 && !r_v2) begin
                    w_state_nxt = ST_HOLD;
                    w_load      = 1'b1;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_ACCUM;
                    w_release   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_ACCUM;
            end
        endcase
    end

    // Two-stage subtract/magnitude pipeline feeding the accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d      <= '0;
            r_borrow <= 1'b0;
            r_v1     <= 1'b0;
            r_mag    <= '0;
            r_v2     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_d      <= w_diff[WIDTH-1:0];
                r_borrow <= ~w_diff[WIDTH];
            end
            r_v1  <= w_accept;
            r_mag <= w_mag;
            r_v2  <= r_v1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_release) begin
            r_count <= '0;
            r_acc   <= '0;
        end else begin
            if (w_accept) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (r_v2) begin
                r_acc <= r_acc + ACC_W'(r_mag);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sad       <= '0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_sad       <= r_acc;
        end else if (w_release) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef SAD_SPIKE_EN
    logic r_spike;

    always_ff @(posedge clk) begin
        if (rst || w_release) begin
            r_spike <= 1'b0;
        end else if (w_load) begin
            r_spike <= (r_acc > thresh);
        end
    end

    assign spike = r_spike;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sad_abs_diff_accumulator.sv
// ============================================================================
// Module   : tb_sad_abs_diff_accumulator
// Purpose  : Directed and random stimulus against a window-level SAD model.
// Options  : SAD_SPIKE_EN also exercises thresh/spike.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sad_abs_diff_accumulator;

    localparam int WIDTH  = 8;
    localparam int WINDOW = 16;
    localparam int ACC_W  = 12;
    localparam int CNT_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sad;
    logic             busy;
    logic [ACC_W-1:0] thresh;
    logic             spike;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    sad_abs_diff_accumulator #(
        .WIDTH (WIDTH),
        .WINDOW(WINDOW),
        .ACC_W (ACC_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sad      (sad),
        .busy     (busy)
`ifdef SAD_SPIKE_EN
        ,
        .thresh   (thresh),
        .spike    (spike)
`endif
    );

`ifndef SAD_SPIKE_EN
    assign spike = 1'b0;
`endif

    always #5 clk = ~clk;

    initial begin
        if ((longint'(1) << ACC_W) <= longint'(WINDOW) * ((longint'(1) << WIDTH) - 1)) begin
            $display("FAIL acc_w_rule: ACC_W=%0d too narrow for WINDOW=%0d", ACC_W, WINDOW);
            $fatal(1, "parameter rule violated");
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Window-level model: counts accepted pairs, sums |a-b|, result appears
    // three edges after the window's last accept and is held until taken.
    typedef struct {
        int cnt;
        int sum;
        int due;
        bit ov;
        int sad;
        bit spike;
    } model_t;

    model_t m;

    function automatic model_t step(input model_t s, input bit r, input bit iv,
                                    input int ia, input int ib, input bit ordy,
                                    input int th);
        model_t n;
        n = s;
        if (r) begin
            n.cnt = 0; n.sum = 0; n.due = 0; n.ov = 0; n.sad = 0; n.spike = 0;
        end else if (n.due > 0) begin
            n.due = n.due - 1;
            if (n.due == 0) begin
                n.ov    = 1;
                n.sad   = n.sum;
                n.spike = (n.sum > th);
            end
        end else if (n.ov && ordy) begin
            n.ov = 0; n.cnt = 0; n.sum = 0; n.spike = 0;
        end else if (iv && n.cnt < WINDOW) begin
            n.sum = n.sum + ((ia > ib) ? (ia - ib) : (ib - ia));
            n.cnt = n.cnt + 1;
            if (n.cnt == WINDOW) n.due = 3;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= step(m, rst, in_valid, int'(a), int'(b), out_ready, int'(thresh));
    end

    always @(negedge clk) begin
        if (started) begin
            check("in_ready",  in_ready,  (m.cnt < WINDOW) ? 1 : 0);
            check("out_valid", out_valid, m.ov);
            check("sad",       sad,       m.sad);
            check("busy",      busy,      (m.cnt != 0) ? 1 : 0);
`ifdef SAD_SPIKE_EN
            check("spike",     spike,     m.spike);
`endif
        end
    end

    task automatic pick(input int kind, input int i);
        case (kind)
            1: begin a = 8'd10;  b = 8'd3;   end
            2: begin a = 8'd3;   b = 8'd10;  end
            3: begin a = 8'd0;   b = 8'd255; end
            4: begin
                if (i < 8) begin a = 8'd77;  b = 8'd77;  end
                else       begin a = 8'd200; b = 8'd100; end
            end
            default: begin a = 8'd1; b = 8'd0; end
        endcase
    endtask

    task automatic wait_in_ready();
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("in_ready_timeout", in_ready, 1);
    endtask

    task automatic do_window(input int kind, input int exp_sad, input bit keep_valid);
        int n;
        wait_in_ready();
        for (int i = 0; i < WINDOW; i++) begin
            in_valid = 1'b1;
            pick(kind, i);
            @(posedge clk); #1;
        end
        if (!keep_valid) in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        n = 0;
        while (!out_valid && n < 10) begin
            check("drain_in_ready", in_ready, 0);
            @(posedge clk); #1;
            n++;
        end
        check("result_latency", n, 3);
        check("sad_literal", sad, exp_sad);
        check("model_pin", m.sad, exp_sad);
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("hs_out_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_spike", spike, 0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        thresh    = 12'd111;
        @(posedge clk); #1;
        started = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sad", sad, 0);
        check("rst_busy", busy, 0);

        // positive differences, spike expected with thresh just below result
        out_ready = 1'b1;
        do_window(1, 112, 1'b0);
`ifdef SAD_SPIKE_EN
        check("spike_above", spike, 1);
`endif
        handshake();
        thresh = 12'd112;
        do_window(1, 112, 1'b0);
`ifdef SAD_SPIKE_EN
        check("spike_equal", spike, 0);
`endif
        handshake();

        do_window(2, 112, 1'b0);
        handshake();
        do_window(3, 4080, 1'b0);
        handshake();
        do_window(4, 800, 1'b0);
        handshake();

        // backpressure with in_valid held high through HOLD
        out_ready = 1'b0;
        do_window(1, 112, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check("bp_out_valid", out_valid, 1);
            check("bp_sad", sad, 112);
            check("bp_in_ready", in_ready, 0);
        end
        handshake();
        do_window(5, 16, 1'b0);
        handshake();

        // reset in the middle of a window with the pipeline occupied
        wait_in_ready();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_sad", sad, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        do_window(5, 16, 1'b0);
        handshake();

        // random traffic, checked cycle by cycle against the model
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 15) == 0) thresh = 12'($urandom_range(0, 4095));
            rst       = ($urandom_range(0, 499) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
